pipelined_control_unit: RTL

Next-generation control unit for the 5-stage MIPS datapath. It decodes the full integer subset (R-type ALU and shift ops, immediate ALU ops, LW/SW, BEQ/BNE, LUI, J/JAL/JR) in ID. It adds load-use hazard detection, forwarding-select generation and a branch flush. All control for EX/MEM/WB is delivered through a registered ID/EX control bank, so downstream stages see stable, pipelined control.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/hazard_fwd_unit.sv | 60 ++++++
 rtl/pipelined_control_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline control slice: opcode/func fields,
// ALU control codes, forwarding-select encodings and the ID/EX control word.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  // ALU control codes (4-bit core encoding)
  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_XOR = 4'b0011;
  localparam logic [3:0] ALUC_LUI = 4'b0100;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b1000;
  localparam logic [3:0] ALUC_SRL = 4'b1001;
  localparam logic [3:0] ALUC_SRA = 4'b1010;

  // Operand-select encodings for EX
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  // Control word carried from ID into the ID/EX bank
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       regrt;
    logic       shift;
    logic       jal;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       jr;
    logic [3:0] aluc;
  } ctrl_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection and forwarding-select generation for the
// instruction in ID, checked against the EX and MEM stage destinations.
module hazard_fwd_unit
  import mips_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic            id_valid,
  input  logic            flush,
  input  logic            uses_rs,
  input  logic            uses_rt,
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] rt,
  input  logic            ex_dst_w,
  input  logic            ex_m2reg_i,
  input  logic [RA_W-1:0] ex_rn,
  input  logic            mem_wreg,
  input  logic            mem_m2reg,
  input  logic [RA_W-1:0] mem_rn,
  output logic            stall,
  output logic [1:0]      fwda,
  output logic [1:0]      fwdb
);

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic load_use, raw_any;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  assign ex_hit_a  = ex_dst_w && (ex_rn  != '0) && (ex_rn  == rs);
  assign ex_hit_b  = ex_dst_w && (ex_rn  != '0) && (ex_rn  == rt);
  assign mem_hit_a = mem_wreg && (mem_rn != '0) && (mem_rn == rs);
  assign mem_hit_b = mem_wreg && (mem_rn != '0) && (mem_rn == rt);

  assign load_use = ex_m2reg_i && ((uses_rs && ex_hit_a) || (uses_rt && ex_hit_b));
  assign raw_any  = (uses_rs && (ex_hit_a || mem_hit_a)) ||
                    (uses_rt && (ex_hit_b || mem_hit_b));

  // Stall: load-use always; any RAW against EX/MEM when forwarding is off.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      if (FWD_EN != 0) stall = load_use;
      else             stall = load_use || raw_any;
    end
  end

  // Forwarding selects: youngest non-load producer first, then MEM stage.
  always_comb begin
    fwda = FWD_REG;
    fwdb = FWD_REG;
    if (FWD_EN != 0) begin
      if (ex_hit_a && !ex_m2reg_i) fwda = FWD_EX;
      else if (mem_hit_a)          fwda = mem_m2reg ? FWD_LD : FWD_MEM;
      if (ex_hit_b && !ex_m2reg_i) fwdb = FWD_EX;
      else if (mem_hit_b)          fwdb = mem_m2reg ? FWD_LD : FWD_MEM;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: decodes the integer subset, consults the hazard /
// forwarding unit and registers everything EX/MEM/WB need into the ID/EX bank.
module pipelined_control_unit
  import mips_pkg::*;
#(
  parameter int ALUC_W = 4,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic              flush,
  input  logic              ex_dst_w,
  input  logic              ex_m2reg_i,
  input  logic [RA_W-1:0]   ex_rn,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [RA_W-1:0]   mem_rn,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_wreg,
  output logic              ex_m2reg,
  output logic              ex_wmem,
  output logic              ex_aluimm,
  output logic              ex_regrt,
  output logic              ex_shift,
  output logic              ex_jal,
  output logic              ex_branch,
  output logic              ex_bne,
  output logic              ex_jump,
  output logic              ex_jr,
  output logic [ALUC_W-1:0] ex_aluc,
  output logic [1:0]        ex_fwda,
  output logic [1:0]        ex_fwdb
);

  ctrl_t      dec;
  logic       dec_ok;
  logic       uses_rs, uses_rt;
  logic       hz_stall;
  logic [1:0] fwda, fwdb;

  ctrl_t      ctrl_q;
  logic       valid_q;
  logic [1:0] fwda_q, fwdb_q;

  // Decode op/func into a control word; unknown encodings become a bubble.
  always_comb begin
    dec     = '0;
    dec_ok  = 1'b1;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rt  = 1'b1;
        dec.wreg = 1'b1;
        case (func)
          FN_ADD: dec.aluc = ALUC_ADD;
          FN_SUB: dec.aluc = ALUC_SUB;
          FN_AND: dec.aluc = ALUC_AND;
          FN_OR:  dec.aluc = ALUC_OR;
          FN_XOR: dec.aluc = ALUC_XOR;
          FN_SLL: begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRL: begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRA: begin dec.aluc = ALUC_SRA; dec.shift = 1'b1; uses_rs = 1'b0; end
          FN_JR:  begin dec.wreg = 1'b0; dec.jr = 1'b1; end
          default: begin dec = '0; dec_ok = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        dec.wreg   = 1'b1;
        dec.aluimm = 1'b1;
        dec.regrt  = 1'b1;
        dec.m2reg  = (op == OP_LW);
        case (op)
          OP_ANDI: dec.aluc = ALUC_AND;
          OP_ORI:  dec.aluc = ALUC_OR;
          OP_XORI: dec.aluc = ALUC_XOR;
          OP_LUI:  begin dec.aluc = ALUC_LUI; uses_rs = 1'b0; end
          default: dec.aluc = ALUC_ADD;
        endcase
      end
      // Store address is rs + immediate, so the ALU takes the immediate too.
      OP_SW: begin
        dec.wmem   = 1'b1;
        dec.aluimm = 1'b1;
        dec.aluc   = ALUC_ADD;
        uses_rt    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.branch = 1'b1;
        dec.bne    = (op == OP_BNE);
        dec.aluc   = ALUC_SUB;
        uses_rt    = 1'b1;
      end
      OP_J: begin
        dec.jump = 1'b1;
        uses_rs  = 1'b0;
      end
      OP_JAL: begin
        dec.jump = 1'b1;
        dec.jal  = 1'b1;
        dec.wreg = 1'b1;
        uses_rs  = 1'b0;
      end
      default: begin
        dec_ok  = 1'b0;
        uses_rs = 1'b0;
      end
    endcase
  end

  hazard_fwd_unit #(
    .RA_W  (RA_W),
    .FWD_EN(FWD_EN)
  ) u_hazard (
    .id_valid  (id_valid),
    .flush     (flush),
    .uses_rs   (uses_rs),
    .uses_rt   (uses_rt),
    .rs        (rs),
    .rt        (rt),
    .ex_dst_w  (ex_dst_w),
    .ex_m2reg_i(ex_m2reg_i),
    .ex_rn     (ex_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .stall     (hz_stall),
    .fwda      (fwda),
    .fwdb      (fwdb)
  );

  // Stall is held low while reset is asserted so PC/IF-ID are not frozen.
  assign stall = rst_n && hz_stall;

  // ID/EX bank: reset, else bubble on flush/stall/empty/unknown, else load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      fwda_q  <= FWD_REG;
      fwdb_q  <= FWD_REG;
    end else if (flush || hz_stall || !id_valid || !dec_ok) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      fwda_q  <= FWD_REG;
      fwdb_q  <= FWD_REG;
    end else begin
      valid_q <= 1'b1;
      ctrl_q  <= dec;
      fwda_q  <= fwda;
      fwdb_q  <= fwdb;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_wreg   = ctrl_q.wreg;
  assign ex_m2reg  = ctrl_q.m2reg;
  assign ex_wmem   = ctrl_q.wmem;
  assign ex_aluimm = ctrl_q.aluimm;
  assign ex_regrt  = ctrl_q.regrt;
  assign ex_shift  = ctrl_q.shift;
  assign ex_jal    = ctrl_q.jal;
  assign ex_branch = ctrl_q.branch;
  assign ex_bne    = ctrl_q.bne;
  assign ex_jump   = ctrl_q.jump;
  assign ex_jr     = ctrl_q.jr;
  assign ex_aluc   = ALUC_W'(ctrl_q.aluc);
  assign ex_fwda   = fwda_q;
  assign ex_fwdb   = fwdb_q;

endmodule
